// File: rtl/aud_sram_ctrl.sv
// Audio lab sequencer: key-driven record/play/pause/stop FSM that owns the
// shared SRAM port, writes recorder samples and fetches one sample per frame.
module aud_sram_ctrl #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_rec_start,
  input  logic              i_play_start,
  input  logic              i_pause,
  input  logic              i_stop,
  input  logic              i_daclrck,
  input  logic [ADDR_W-1:0] i_rec_addr,
  input  logic [DATA_W-1:0] i_rec_data,
  output logic              o_rec_start,
  output logic              o_rec_pause,
  output logic              o_rec_stop,
  output logic              o_play_en,
  output logic [DATA_W-1:0] o_dac_data,
  output logic [ADDR_W-1:0] o_sram_addr,
  output logic [DATA_W-1:0] o_sram_wdata,
  input  logic [DATA_W-1:0] i_sram_rdata,
  output logic              o_sram_we_n,
  output logic              o_sram_oe_n,
  output logic [2:0]        o_state,
  output logic [ADDR_W-1:0] o_end_addr,
  output logic              o_has_data
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    REC        = 3'd1,
    REC_PAUSE  = 3'd2,
    PLAY       = 3'd3,
    PLAY_PAUSE = 3'd4
  } state_t;

  state_t              state_reg, state_next;
  logic                rec_start_reg, rec_pause_reg, rec_stop_reg, play_en_reg;
  logic                rec_start_next, rec_pause_next, rec_stop_next;
  logic [DATA_W-1:0]   dac_data_reg;
  logic [ADDR_W-1:0]   sram_addr_reg, last_addr_reg, end_addr_reg, play_addr_reg;
  logic [DATA_W-1:0]   sram_wdata_reg;
  logic                we_n_reg, oe_n_reg, has_data_reg;
  logic                lrck_s1_reg, lrck_s2_reg, lrck_d_reg;
  logic                fetch_pend_reg, full_pend_reg;
  logic                in_rec, lrck_rise, do_write, do_fetch, last_fetch;

  assign in_rec     = (state_reg == REC) || (state_reg == REC_PAUSE);
  assign lrck_rise  = lrck_s2_reg && !lrck_d_reg;
  assign do_write   = in_rec && (i_rec_addr != last_addr_reg) && !full_pend_reg;
  // A key that leaves PLAY this cycle suppresses the fetch entirely.
  assign do_fetch   = (state_reg == PLAY) && lrck_rise && !i_stop && !i_pause
                      && !fetch_pend_reg;
  assign last_fetch = fetch_pend_reg && (play_addr_reg == end_addr_reg);

  always_comb begin
    state_next     = state_reg;
    rec_start_next = 1'b0;
    rec_pause_next = 1'b0;
    rec_stop_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!i_stop && !i_pause) begin
          if (i_rec_start) begin
            state_next     = REC;
            rec_start_next = 1'b1;
          end else if (i_play_start && has_data_reg) begin
            state_next = PLAY;
          end
        end
      end
      REC: begin
        if (i_stop) begin
          state_next    = IDLE;
          rec_stop_next = 1'b1;
        end else if (i_pause) begin
          state_next     = REC_PAUSE;
          rec_pause_next = 1'b1;
        end
      end
      REC_PAUSE: begin
        if (i_stop) begin
          state_next    = IDLE;
          rec_stop_next = 1'b1;
        end else if (!i_pause && i_rec_start) begin
          state_next     = REC;
          rec_start_next = 1'b1;
        end
      end
      PLAY: begin
        if (i_stop)       state_next = IDLE;
        else if (i_pause) state_next = PLAY_PAUSE;
      end
      PLAY_PAUSE: begin
        if (i_stop)                          state_next = IDLE;
        else if (!i_pause && i_play_start)   state_next = PLAY;
      end
      default: state_next = IDLE;
    endcase
    // Memory full: the top-address write just completed, so stop recording.
    if (full_pend_reg && in_rec) begin
      state_next     = IDLE;
      rec_stop_next  = 1'b1;
      rec_start_next = 1'b0;
      rec_pause_next = 1'b0;
    end
    if (last_fetch && (state_reg == PLAY || state_reg == PLAY_PAUSE))
      state_next = IDLE;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg      <= IDLE;
      rec_start_reg  <= 1'b0;
      rec_pause_reg  <= 1'b0;
      rec_stop_reg   <= 1'b0;
      play_en_reg    <= 1'b0;
      dac_data_reg   <= '0;
      sram_addr_reg  <= '0;
      sram_wdata_reg <= '0;
      we_n_reg       <= 1'b1;
      oe_n_reg       <= 1'b1;
      last_addr_reg  <= '0;
      end_addr_reg   <= '0;
      play_addr_reg  <= '0;
      has_data_reg   <= 1'b0;
      lrck_s1_reg    <= 1'b0;
      lrck_s2_reg    <= 1'b0;
      lrck_d_reg     <= 1'b0;
      fetch_pend_reg <= 1'b0;
      full_pend_reg  <= 1'b0;
    end else begin
      lrck_s1_reg    <= i_daclrck;
      lrck_s2_reg    <= lrck_s1_reg;
      lrck_d_reg     <= lrck_s2_reg;
      state_reg      <= state_next;
      rec_start_reg  <= rec_start_next;
      rec_pause_reg  <= rec_pause_next;
      rec_stop_reg   <= rec_stop_next;
      play_en_reg    <= (state_next == PLAY);
      we_n_reg       <= 1'b1;
      oe_n_reg       <= 1'b1;
      fetch_pend_reg <= 1'b0;
      full_pend_reg  <= 1'b0;

      if (state_reg == IDLE && state_next == REC) begin
        has_data_reg  <= 1'b0;
        end_addr_reg  <= '0;
        last_addr_reg <= i_rec_addr;
      end
      if (state_reg == IDLE && state_next == PLAY) begin
        play_addr_reg <= '0;
        dac_data_reg  <= '0;
      end

      if (do_write) begin
        sram_addr_reg  <= i_rec_addr;
        sram_wdata_reg <= i_rec_data;
        we_n_reg       <= 1'b0;
        end_addr_reg   <= i_rec_addr;
        has_data_reg   <= 1'b1;
        last_addr_reg  <= i_rec_addr;
        full_pend_reg  <= &i_rec_addr;
      end

      if (do_fetch) begin
        sram_addr_reg  <= play_addr_reg;
        oe_n_reg       <= 1'b0;
        fetch_pend_reg <= 1'b1;
      end
      if (fetch_pend_reg) begin
        dac_data_reg  <= i_sram_rdata;
        play_addr_reg <= play_addr_reg + 1'b1;
      end
    end
  end

  assign o_rec_start  = rec_start_reg;
  assign o_rec_pause  = rec_pause_reg;
  assign o_rec_stop   = rec_stop_reg;
  assign o_play_en    = play_en_reg;
  assign o_dac_data   = dac_data_reg;
  assign o_sram_addr  = sram_addr_reg;
  assign o_sram_wdata = sram_wdata_reg;
  assign o_sram_we_n  = we_n_reg;
  assign o_sram_oe_n  = oe_n_reg;
  assign o_state      = state_reg;
  assign o_end_addr   = end_addr_reg;
  assign o_has_data   = has_data_reg;

endmodule

// File: tb/tb_aud_sram_ctrl.sv
// Directed bench for aud_sram_ctrl with a small behavioural SRAM attached.
module tb_aud_sram_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rec_start_k, play_start_k, pause_k, stop_k, daclrck;
  logic [19:0] rec_addr;
  logic [15:0] rec_data;
  logic        rec_start, rec_pause, rec_stop, play_en;
  logic [15:0] dac_data, sram_wdata, sram_rdata;
  logic [19:0] sram_addr, end_addr;
  logic        sram_we_n, sram_oe_n, has_data;
  logic [2:0]  state;

  int total = 0;
  int bad = 0;
  int we_cnt = 0;
  int oe_cnt = 0;
  int stop_cnt = 0;
  int clash_cnt = 0;
  int oe_snap;

  logic [15:0] mem [0:15];

  always #5 clk = ~clk;

  aud_sram_ctrl dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_rec_start(rec_start_k), .i_play_start(play_start_k),
    .i_pause(pause_k), .i_stop(stop_k), .i_daclrck(daclrck),
    .i_rec_addr(rec_addr), .i_rec_data(rec_data),
    .o_rec_start(rec_start), .o_rec_pause(rec_pause), .o_rec_stop(rec_stop),
    .o_play_en(play_en), .o_dac_data(dac_data),
    .o_sram_addr(sram_addr), .o_sram_wdata(sram_wdata), .i_sram_rdata(sram_rdata),
    .o_sram_we_n(sram_we_n), .o_sram_oe_n(sram_oe_n),
    .o_state(state), .o_end_addr(end_addr), .o_has_data(has_data)
  );

  always @(posedge clk) if (!sram_we_n) mem[sram_addr[3:0]] <= sram_wdata;
  assign sram_rdata = sram_oe_n ? 16'hDEAD : mem[sram_addr[3:0]];

  always @(negedge clk) begin
    if (!sram_we_n) we_cnt++;
    if (!sram_oe_n) oe_cnt++;
    if (rec_stop) stop_cnt++;
    if (!sram_we_n && !sram_oe_n) clash_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One LR frame: rising edge, fetch at F (3 cycles later), latch at F+1.
  task automatic frame(input string tag, input logic [19:0] exp_addr, input logic [15:0] exp_data);
    daclrck = 1'b1;
    tick(); tick(); tick();
    chk({tag, "_oe"}, {31'd0, sram_oe_n}, 32'd0);
    chk({tag, "_addr"}, {12'd0, sram_addr}, {12'd0, exp_addr});
    tick();
    chk({tag, "_dac"}, {16'd0, dac_data}, {16'd0, exp_data});
    $display("fetch %s addr=%h dac=%h state=%0d", tag, exp_addr, dac_data, state);
    daclrck = 1'b0;
    tick(); tick(); tick();
  endtask

  task automatic press(input int which);
    case (which)
      0: rec_start_k = 1'b1;
      1: play_start_k = 1'b1;
      2: pause_k = 1'b1;
      default: stop_k = 1'b1;
    endcase
    tick();
    rec_start_k = 1'b0; play_start_k = 1'b0; pause_k = 1'b0; stop_k = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    rec_start_k = 1'b0; play_start_k = 1'b0; pause_k = 1'b0; stop_k = 1'b0;
    daclrck = 1'b0; rec_addr = 20'h12345; rec_data = 16'h0;
    tick(); tick();
    chk("rst_state", {29'd0, state}, 32'd0);
    chk("rst_we", {31'd0, sram_we_n}, 32'd1);
    chk("rst_oe", {31'd0, sram_oe_n}, 32'd1);
    chk("rst_hasdata", {31'd0, has_data}, 32'd0);
    chk("rst_cmds", {28'd0, rec_start, rec_pause, rec_stop, play_en}, 32'd0);
    $display("reset state=%0d we_n=%b oe_n=%b", state, sram_we_n, sram_oe_n);
    rst_n = 1'b1;
    tick();

    // Record five back-to-back samples.
    press(0);
    chk("rec_state", {29'd0, state}, 32'd1);
    chk("rec_start_pulse", {31'd0, rec_start}, 32'd1);
    for (int n = 0; n < 5; n++) begin
      rec_addr = 20'(n);
      rec_data = 16'h1000 + 16'(n);
      tick();
      if (n == 0) chk("rec_start_1cyc", {31'd0, rec_start}, 32'd0);
      chk("wr_we", {31'd0, sram_we_n}, 32'd0);
      chk("wr_addr", {12'd0, sram_addr}, n);
      chk("wr_data", {16'd0, sram_wdata}, 32'h1000 + n);
      $display("write addr=%h data=%h we_n=%b", sram_addr, sram_wdata, sram_we_n);
    end
    tick();
    chk("wr_done_we", {31'd0, sram_we_n}, 32'd1);
    chk("end_addr4", {12'd0, end_addr}, 32'd4);
    chk("has_data1", {31'd0, has_data}, 32'd1);
    press(3);
    chk("stop_state", {29'd0, state}, 32'd0);
    chk("stop_pulse", {31'd0, rec_stop}, 32'd1);
    tick();
    chk("stop_1cyc", {31'd0, rec_stop}, 32'd0);
    chk("we_cnt5", we_cnt, 32'd5);

    // Full playback to the end.
    press(1);
    chk("play_state", {29'd0, state}, 32'd3);
    chk("play_en", {31'd0, play_en}, 32'd1);
    for (int n = 0; n < 5; n++) frame("play", 20'(n), 16'h1000 + 16'(n));
    chk("play_end_state", {29'd0, state}, 32'd0);
    chk("play_end_en", {31'd0, play_en}, 32'd0);
    chk("play_end_dac", {16'd0, dac_data}, 32'h1004);

    // Pause after two samples, then resume at address 2.
    press(1);
    chk("p2_dac_clear", {16'd0, dac_data}, 32'd0);
    frame("p2", 20'd0, 16'h1000);
    frame("p2", 20'd1, 16'h1001);
    press(2);
    chk("pause_state", {29'd0, state}, 32'd4);
    chk("pause_en", {31'd0, play_en}, 32'd0);
    oe_snap = oe_cnt;
    daclrck = 1'b1;
    repeat (6) tick();
    daclrck = 1'b0;
    repeat (4) tick();
    chk("pause_hold", {16'd0, dac_data}, 32'h1001);
    chk("pause_noread", oe_cnt, oe_snap);
    press(1);
    chk("resume_state", {29'd0, state}, 32'd3);
    frame("resume", 20'd2, 16'h1002);
    press(3);
    chk("pstop_state", {29'd0, state}, 32'd0);

    // Asynchronous reset in the middle of PLAY.
    press(1);
    frame("prerst", 20'd0, 16'h1000);
    chk("prerst_state", {29'd0, state}, 32'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_state", {29'd0, state}, 32'd0);
    chk("arst_en", {31'd0, play_en}, 32'd0);
    chk("arst_dac", {16'd0, dac_data}, 32'd0);
    chk("arst_hasdata", {31'd0, has_data}, 32'd0);
    chk("arst_addr", {12'd0, sram_addr}, 32'd0);
    chk("arst_end", {12'd0, end_addr}, 32'd0);
    $display("async reset state=%0d dac=%h has_data=%b", state, dac_data, has_data);
    #2 rst_n = 1'b1;
    tick();

    // Play with nothing recorded is ignored.
    oe_snap = oe_cnt;
    press(1);
    chk("nodata_state", {29'd0, state}, 32'd0);
    daclrck = 1'b1;
    repeat (5) tick();
    daclrck = 1'b0;
    repeat (4) tick();
    chk("nodata_noread", oe_cnt, oe_snap);

    // Simultaneous rec/play start: record wins.
    rec_start_k = 1'b1;
    press(1);
    chk("both_state", {29'd0, state}, 32'd1);
    press(3);

    // Memory-full write terminates recording.
    rec_addr = 20'hFFFFD;
    press(0);
    chk("full_rec", {29'd0, state}, 32'd1);
    rec_addr = 20'hFFFFE; rec_data = 16'hAAAA;
    tick();
    rec_addr = 20'hFFFFF; rec_data = 16'hBBBB;
    tick();
    chk("full_we", {31'd0, sram_we_n}, 32'd0);
    chk("full_addr", {12'd0, sram_addr}, 32'hFFFFF);
    chk("full_nostop_yet", {31'd0, rec_stop}, 32'd0);
    tick();
    chk("full_stop", {31'd0, rec_stop}, 32'd1);
    chk("full_idle", {29'd0, state}, 32'd0);
    chk("full_end", {12'd0, end_addr}, 32'hFFFFF);
    chk("full_we_rel", {31'd0, sram_we_n}, 32'd1);
    $display("full stop state=%0d end_addr=%h", state, end_addr);
    tick();
    chk("full_stop_1cyc", {31'd0, rec_stop}, 32'd0);

    chk("we_total", we_cnt, 32'd7);
    chk("oe_total", oe_cnt, 32'd9);
    chk("stop_total", stop_cnt, 32'd3);
    chk("no_clash", clash_cnt, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
